// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//   Buffered RV32I instruction encoder. Accepts a set of instruction fields
//   over a valid/ready handshake, packs them into a 32-bit instruction word,
//   flags immediates that cannot be represented in the chosen format, and
//   presents the result through a 2-entry output FIFO.
//
// Parameters
//   CNT_W     width of the output-handshake counter
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous reset, active low
//   i_valid   input field set valid
//   o_ready   encoder can accept a field set (FIFO not full)
//   i_fmt     0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   i_opcode  opcode, copied into bits [6:0]
//   i_funct3  funct3 (R/I/S/B)
//   i_funct7  funct7 (R)
//   i_rd      destination register
//   i_rs1     source register 1
//   i_rs2     source register 2
//   i_imm     signed byte immediate (U: full value, imm[31:12] used)
//   o_valid   FIFO head holds an encoded word
//   i_ready   consumer takes the head word when high with o_valid
//   o_inst    encoded word at FIFO head
//   o_err     head word failed the immediate legality check
//   o_count   number of output handshakes, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_fmt,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic [6:0]       i_funct7,
    input  logic [4:0]       i_rd,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [31:0]      i_imm,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_inst,
    output logic             o_err,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // The control state encoding doubles as the FIFO occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // Combinational encoder
    // -------------------------------------------------------------------------
    logic [31:0] enc_inst;
    logic        enc_err;

    // Sign-extension checks: every bit above the field's sign bit must match it.
    logic sx12_ok;   // fits imm[11:0]
    logic sx13_ok;   // fits imm[12:0]
    logic sx21_ok;   // fits imm[20:0]

    assign sx12_ok = (i_imm[31:11] == {21{i_imm[11]}});
    assign sx13_ok = (i_imm[31:12] == {20{i_imm[12]}});
    assign sx21_ok = (i_imm[31:20] == {12{i_imm[20]}});

    always_comb begin
        enc_inst = 32'h0000_0000;
        enc_err  = 1'b0;
        unique case (i_fmt)
            FMT_R: begin
                enc_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            end
            FMT_I: begin
                enc_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                enc_err  = ~sx12_ok;
            end
            FMT_S: begin
                enc_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                enc_err  = ~sx12_ok;
            end
            FMT_B: begin
                enc_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                            i_imm[4:1], i_imm[11], i_opcode};
                // Branch offsets are halfword aligned; bit 0 is not encodable.
                enc_err  = ~sx13_ok | i_imm[0];
            end
            FMT_U: begin
                enc_inst = {i_imm[31:12], i_rd, i_opcode};
                // The low 12 bits are dropped, so any set bit would be lost.
                enc_err  = (i_imm[11:0] != 12'h000);
            end
            FMT_J: begin
                enc_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                            i_rd, i_opcode};
                enc_err  = ~sx21_ok | i_imm[0];
            end
            default: begin
                // Illegal format: emit an all-zero word and flag it.
                enc_inst = 32'h0000_0000;
                enc_err  = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO control FSM
    // -------------------------------------------------------------------------
    state_e state_q, state_d;
    logic   ready;
    logic   valid;
    logic   push;
    logic   pop;

    // Ready depends only on the registered state, so there is never a
    // combinational path from i_ready to o_ready. At FULL the input is
    // refused even if the head is popped in the same cycle.
    assign push = i_valid & ready;
    assign pop  = valid & i_ready;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: begin
                if (push) state_d = S_ONE;
            end
            S_ONE: begin
                if (push && !pop)      state_d = S_FULL;
                else if (!push && pop) state_d = S_EMPTY;
                else                   state_d = S_ONE;
            end
            S_FULL: begin
                if (pop) state_d = S_ONE;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        ready = 1'b0;
        valid = 1'b0;
        case (state_q)
            S_EMPTY: begin
                ready = 1'b1;
                valid = 1'b0;
            end
            S_ONE: begin
                ready = 1'b1;
                valid = 1'b1;
            end
            S_FULL: begin
                ready = 1'b0;
                valid = 1'b1;
            end
            default: begin
                ready = 1'b0;
                valid = 1'b0;
            end
        endcase
    end

    assign o_ready = ready;
    assign o_valid = valid;

    // -------------------------------------------------------------------------
    // Storage and pointers
    // -------------------------------------------------------------------------
    logic [1:0][31:0] mem_q;
    logic [1:0]       err_q;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;

    assign wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    assign rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q    <= '0;
            err_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= enc_inst;
                err_q[wr_ptr_q] <= enc_err;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Head entry comes straight from registered storage; it cannot change
    // while stalled because only the tail slot is written and the read
    // pointer only moves on a pop.
    assign o_inst = mem_q[rd_ptr_q];
    assign o_err  = err_q[rd_ptr_q];

    // -------------------------------------------------------------------------
    // Output handshake counter
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = pop ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  localparam int CNT_W = 16;

  localparam logic [2:0] F_R = 3'd0;
  localparam logic [2:0] F_I = 3'd1;
  localparam logic [2:0] F_S = 3'd2;
  localparam logic [2:0] F_B = 3'd3;
  localparam logic [2:0] F_U = 3'd4;
  localparam logic [2:0] F_J = 3'd5;

  logic             clk;
  logic             rst_n;
  logic             in_vld;
  logic             in_rdy;
  logic [2:0]       fmt;
  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [4:0]       rd, rs1, rs2;
  logic [31:0]      imm;
  logic             out_vld;
  logic             out_rdy;
  logic [31:0]      inst;
  logic             err;
  logic [CNT_W-1:0] cnt;

  int n_chk  = 0;
  int n_pass = 0;

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (in_vld),
    .o_ready  (in_rdy),
    .i_fmt    (fmt),
    .i_opcode (opc),
    .i_funct3 (f3),
    .i_funct7 (f7),
    .i_rd     (rd),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .i_imm    (imm),
    .o_valid  (out_vld),
    .i_ready  (out_rdy),
    .o_inst   (inst),
    .o_err    (err),
    .o_count  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] o, input logic [2:0] a3,
                       input logic [6:0] a7, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    fmt = f; opc = o; f3 = a3; f7 = a7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_vld = 1'b1;
  endtask

  task automatic push1(input logic [2:0] f, input logic [6:0] o, input logic [2:0] a3,
                       input logic [6:0] a7, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    drive(f, o, a3, a7, d, s1, s2, im);
    step();
    in_vld = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] exp_inst, input logic exp_err);
    chk({tag, ".vld"}, {31'd0, out_vld}, 32'd1);
    chk({tag, ".inst"}, inst, exp_inst);
    chk({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    fmt = '0; opc = '0; f3 = '0; f7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;

    // reset state
    step(); step();
    chk("rst.vld",   {31'd0, out_vld}, 32'd0);
    chk("rst.rdy",   {31'd0, in_rdy},  32'd1);
    chk("rst.inst",  inst,             32'd0);
    chk("rst.err",   {31'd0, err},     32'd0);
    chk("rst.count", {16'd0, cnt},     32'd0);
    rst_n = 1'b1;

    // single words, consumer always ready
    out_rdy = 1'b1;
    push1(F_U, 7'h37, 3'd0, 7'd0, 5'd5,  5'd0, 5'd0,  32'h0007_B000); chk_out("U",  32'h0007b2b7, 1'b0);
    push1(F_J, 7'h6F, 3'd0, 7'd0, 5'd23, 5'd0, 5'd0,  32'd1232);      chk_out("J",  32'h4d000bef, 1'b0);
    push1(F_B, 7'h63, 3'd4, 7'd0, 5'd0,  5'd4, 5'd25, 32'd42);        chk_out("B",  32'h03924563, 1'b0);
    push1(F_S, 7'h23, 3'd2, 7'd0, 5'd0,  5'd2, 5'd14, 32'd23);        chk_out("S",  32'h00e12ba3, 1'b0);
    push1(F_R, 7'h33, 3'd4, 7'd0, 5'd3,  5'd1, 5'd15, 32'd0);         chk_out("R",  32'h00f0c1b3, 1'b0);
    push1(F_I, 7'h13, 3'd0, 7'd0, 5'd2,  5'd4, 5'd0,  32'd32);        chk_out("I",  32'h02020113, 1'b0);

    // legality errors (word still packed from truncated bits)
    push1(F_B, 7'h63, 3'd4, 7'd0, 5'd0,  5'd4, 5'd25, 32'd43);        chk_out("Bodd", 32'h03924563, 1'b1);
    push1(F_I, 7'h13, 3'd0, 7'd0, 5'd0,  5'd0, 5'd0,  32'd2048);      chk_out("Ibig", 32'h80000013, 1'b1);
    push1(3'd6, 7'h13, 3'd1, 7'd1, 5'd1, 5'd1, 5'd1,  32'd1);         chk_out("F6",   32'h00000000, 1'b1);
    push1(F_U, 7'h37, 3'd0, 7'd0, 5'd5,  5'd0, 5'd0,  32'h0007_B001); chk_out("Ulow", 32'h0007b2b7, 1'b1);
    step();
    chk("drain.vld",   {31'd0, out_vld}, 32'd0);
    chk("drain.count", {16'd0, cnt},     32'd10);

    // backpressure: A, B fill the FIFO, C is held off
    rst_n = 1'b0; step(); rst_n = 1'b1;
    out_rdy = 1'b0;
    push1(F_R, 7'h33, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    chk("bp.rdy1", {31'd0, in_rdy}, 32'd1);
    push1(F_R, 7'h33, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd0);
    chk("bp.rdy2", {31'd0, in_rdy}, 32'd0);
    chk("bp.headA", inst, 32'h000000b3);
    drive(F_R, 7'h33, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("bp.hold.rdy",  {31'd0, in_rdy}, 32'd0);
      chk("bp.hold.inst", inst, 32'h000000b3);
    end
    out_rdy = 1'b1;
    step();
    chk("bp.headB", inst, 32'h00000133);
    chk("bp.cnt1",  {16'd0, cnt}, 32'd1);
    step();
    in_vld = 1'b0;
    chk_out("bp.headC", 32'h000001b3, 1'b0);
    step();
    chk("bp.empty", {31'd0, out_vld}, 32'd0);
    chk("bp.count", {16'd0, cnt},     32'd3);

    // simultaneous push/pop at count=1
    rst_n = 1'b0; step(); rst_n = 1'b1;
    out_rdy = 1'b0;
    push1(F_R, 7'h33, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    out_rdy = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      drive(F_R, 7'h33, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'd0);
      step();
      chk("pp.inst", inst, (32'(k) << 7) | 32'h33);
      chk("pp.rdy",  {31'd0, in_rdy}, 32'd1);
    end
    in_vld = 1'b0;
    out_rdy = 1'b0;
    chk("pp.vld",   {31'd0, out_vld}, 32'd1);
    chk("pp.count", {16'd0, cnt},     32'd10);

    // async reset with the FIFO full
    push1(F_R, 7'h33, 3'd0, 7'd0, 5'd31, 5'd0, 5'd0, 32'd0);
    chk("ar.full", {31'd0, in_rdy}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.vld",   {31'd0, out_vld}, 32'd0);
    chk("ar.count", {16'd0, cnt},     32'd0);
    chk("ar.rdy",   {31'd0, in_rdy},  32'd1);
    chk("ar.inst",  inst,             32'd0);
    drive(F_R, 7'h33, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'd0);
    step(); step();
    chk("ar.ignored", {31'd0, out_vld}, 32'd0);
    in_vld = 1'b0;
    rst_n = 1'b1;
    out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ar.nostale", {31'd0, out_vld}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
